// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundles the stall/flush/multi-cycle control signals between
// the datapath stages and the pipeline control unit.
//   master : datapath side; drives the requests, receives stall/flush/status.
//   slave  : pipe_ctrl side; receives the requests, drives stall/flush/status.
// Signals:
//   stallreq_id   ID load-use stall request
//   mc_start      EX multi-cycle op request
//   mc_cycles     stall cycle count N for the op (MC_W bits)
//   mc_cancel     abort running multi-cycle op
//   flush_req     exception/redirect flush request
//   flush_pc      redirect target
//   stall         per-stage hold vector {WB,MEM/WB,EX/MEM,ID/EX,IF/ID,PC}
//   flush         clear all pipeline registers this cycle
//   new_pc        redirect PC, 0 when flush=0
//   mc_busy       sequencer in BUSY
//   mc_done       one-cycle result-valid pulse
//   mc_remaining  sequencer down-counter
//   stall_cycles  saturating count of cycles with stall[0]=1 (PERF_W bits)
interface pipe_ctrl_if #(
  parameter int unsigned MC_W   = 6,
  parameter int unsigned PERF_W = 32
);
  logic              stallreq_id;
  logic              mc_start;
  logic [MC_W-1:0]   mc_cycles;
  logic              mc_cancel;
  logic              flush_req;
  logic [31:0]       flush_pc;
  logic [5:0]        stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic              mc_busy;
  logic              mc_done;
  logic [MC_W-1:0]   mc_remaining;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output stallreq_id, mc_start, mc_cycles, mc_cancel, flush_req, flush_pc,
    input  stall, flush, new_pc, mc_busy, mc_done, mc_remaining, stall_cycles
  );

  modport slave (
    input  stallreq_id, mc_start, mc_cycles, mc_cancel, flush_req, flush_pc,
    output stall, flush, new_pc, mc_busy, mc_done, mc_remaining, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the five-stage core. Merges the ID
// load-use stall and the EX multi-cycle hold into one per-stage stall vector,
// sequences multi-cycle EX operations with a down-counter, issues flush and
// redirect, and keeps a saturating stall-cycle counter.
// Ports:
//   clk  rising-edge system clock
//   rst  asynchronous active-high reset
//   bus  pipe_ctrl_if.slave (requests in; stall/flush/status out)
module pipe_ctrl #(
  parameter int unsigned MC_W   = 6,
  parameter int unsigned PERF_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [5:0] STALL_EX = 6'b001111;
  localparam logic [5:0] STALL_ID = 6'b000111;

  state_t            state_q, state_d;
  logic [MC_W-1:0]   cnt_q, cnt_d;
  logic [PERF_W-1:0] perf_q, perf_d;

  logic       start_ok;
  logic       abort;
  logic       ex_hold;
  logic [5:0] stall_v;
  logic       flush_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perf_q  <= perf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    abort    = bus.flush_req | bus.mc_cancel;
    // Zero-length ops and starts coinciding with cancel/flush are dropped.
    start_ok = (state_q == S_IDLE) && bus.mc_start && !abort &&
               (bus.mc_cycles != '0);

    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          if (bus.mc_cycles == MC_W'(1)) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            state_d = S_BUSY;
            cnt_d   = bus.mc_cycles - 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == MC_W'(1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Stall/flush are gated by rst so every output reads 0 while reset is held,
  // even though they are combinational from the request inputs.
  always_comb begin
    ex_hold = start_ok || (state_q == S_BUSY);
    flush_v = bus.flush_req && !rst;
    stall_v = '0;
    if (rst || bus.flush_req) begin
      stall_v = '0;
    end else if (ex_hold) begin
      stall_v = STALL_EX;
    end else if (bus.stallreq_id) begin
      stall_v = STALL_ID;
    end
  end

  always_comb begin
    perf_d = perf_q;
    if (stall_v[0] && (perf_q != '1)) begin
      perf_d = perf_q + 1'b1;
    end
  end

  assign bus.stall        = stall_v;
  assign bus.flush        = flush_v;
  assign bus.new_pc       = flush_v ? bus.flush_pc : '0;
  assign bus.mc_busy      = (state_q == S_BUSY);
  assign bus.mc_done      = (state_q == S_DONE) && !bus.flush_req && !bus.mc_cancel;
  assign bus.mc_remaining = cnt_q;
  assign bus.stall_cycles = perf_q;

endmodule
